// File: rtl/fifo_pkg.sv
// Shared constants and types for the async-FIFO read-side stream logic.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_CNT_WIDTH  = 16;

  typedef logic [FIFO_DATA_WIDTH-1:0] fifo_word_t;

  // Encoding doubles as the buffer occupancy (0..2).
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus outgoing valid/ready stream, bundled for fifo_rd_stream.
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
);

  logic                  rd_en;
  logic                  empty;
  logic [DATA_WIDTH-1:0] read_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output rd_en,
    input  empty,
    input  read_data,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  rd_en,
    output empty,
    output read_data,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry head/skid output buffer; the head register drives the stream directly.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic [1:0]            count
);

  buf_state_e            state;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  xfer;

  assign xfer  = out_valid & out_ready;
  assign count = state;

  // NOTE: non-blocking assignments so every register samples pre-edge values; head and skid
  // can swap in one edge without ordering hazards.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state     <= BUF_EMPTY;
      out_data  <= '0;
      out_valid <= 1'b0;
      skid_data <= '0;
    end else begin
      unique case (state)
        BUF_EMPTY: begin
          if (in_valid) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          unique case ({in_valid, xfer})
            2'b01: begin
              out_valid <= 1'b0;
              state     <= BUF_EMPTY;
            end
            2'b10: begin
              skid_data <= in_data;
              state     <= BUF_FULL;
            end
            2'b11:   out_data <= in_data;  // arriving word bypasses the skid
            default: ;
          endcase
        end
        BUF_FULL: begin
          if (xfer) begin
            out_data <= skid_data;
            if (in_valid) skid_data <= in_data;
            else          state     <= BUF_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= BUF_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain FIFO consumer: pops against empty, absorbs the 1-cycle read latency,
// and presents words on a registered valid/ready stream with a delivered-word counter.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int CNT_WIDTH  = FIFO_CNT_WIDTH
) (
  input  logic                 rd_clk,
  input  logic                 rst,
  input  logic                 enable,
  fifo_rd_stream_if.master     bus,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 busy
);

  logic [1:0]            count;
  logic                  inflight;
  logic                  xfer;
  logic                  pop;
  logic [2:0]            pending;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_valid;

  assign xfer = head_valid & bus.out_ready;

  // Occupancy once this cycle settles; xfer implies count >= 1, so no underflow.
  assign pending = {1'b0, count} + {2'b00, inflight} - {2'b00, xfer};
  assign pop     = ~rst & enable & ~bus.empty & (pending < 3'd2);

  assign bus.rd_en     = pop;
  assign bus.out_data  = head_data;
  assign bus.out_valid = head_valid;
  assign busy          = inflight | head_valid;

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      inflight   <= 1'b0;
      word_count <= '0;
    end else begin
      inflight <= pop;
      if (xfer) word_count <= word_count + CNT_WIDTH'(1);
    end
  end

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .rd_clk    (rd_clk),
    .rst       (rst),
    .in_valid  (inflight),
    .in_data   (bus.read_data),
    .out_ready (bus.out_ready),
    .out_data  (head_data),
    .out_valid (head_valid),
    .count     (count)
  );

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the async FIFO, clocked entirely in the read domain.
- Issues `rd_en` pops against `empty` and absorbs the FIFO's 1-cycle read latency.
- Presents the words on a registered valid/ready stream for downstream logic.
- Keeps a 2-entry output buffer so that a stalled consumer never loses a word, while sustaining one word per cycle.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.
- CNT_WIDTH, 16, width of the delivered-word counter (wraps modulo 2^CNT_WIDTH).

Ports:
- rd_clk, input, 1, read-domain clock; all logic on its rising edge.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, permits new pops when high; does not affect words already popped.
- empty, input, 1, FIFO empty flag (already synchronized in the read domain).
- read_data, input, DATA_WIDTH, FIFO data; valid exactly 1 cycle after a pop.
- rd_en, output, 1, FIFO pop strobe.
- out_data, output, DATA_WIDTH, stream data (registered).
- out_valid, output, 1, stream valid (registered).
- out_ready, input, 1, stream ready from the consumer.
- word_count, output, CNT_WIDTH, number of stream transfers since reset.
- busy, output, 1, high when a pop is in flight or out_valid is high.

Behaviour:
- Reset (rst=1 at a rising edge):
  - out_valid=0, out_data=0, word_count=0, buffer count=0, inflight=0.
  - rd_en is forced 0 while rst=1.
  - A word returning in the cycle after reset is discarded.
- Definitions:
  - pop = rd_en.
  - xfer = out_valid & out_ready.
  - count = buffer occupancy, 0..2.
  - inflight = registered pop from the previous cycle, 0..1.
- Pop rule (combinational):
  - rd_en = !rst & enable & !empty & ((count + inflight - xfer) < 2).
  - This guarantees buffer occupancy never exceeds 2.
  - The path from out_ready to rd_en is permitted.
- Latency:
  - A word popped at cycle N is captured from read_data at the edge ending cycle N+1.
  - If the buffer was empty, out_valid goes high in cycle N+2.
- Buffer:
  - Head register drives out_data; the skid register holds the second word.
  - On xfer, the skid word moves to the head if present; otherwise out_valid drops unless an arriving word fills the head in the same edge.
  - Simultaneous arrival and xfer with count=1: the arriving word goes directly to the head, count stays 1.
  - Arrival with count=1 and no xfer: the word goes to the skid, count=2.
  - Arrival with count=0: the word goes to the head.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- Order: words leave in exactly FIFO order, with no duplication and no loss.
- Throughput: with out_ready held high and empty low, one transfer per cycle in steady state.
- empty high: no pop issued. Words in flight and in the buffer still drain.
- enable low: stops new pops only. The buffer and in-flight word still drain normally.
- word_count:
  - Increments by 1 on every xfer.
  - Wraps from 2^CNT_WIDTH-1 to 0.
- busy = inflight | out_valid.
- Reset mid-operation (buffer full, pop in flight): all state clears on that edge. The in-flight word is dropped; the FIFO is reset alongside this block.

Decomposition:
- Shared package fifo_pkg:
  - DATA_WIDTH default constant.
  - typedef for a fifo word.
  - CNT_WIDTH default.
- Sub-module fifo_skid_buf: 2-entry head/skid buffer with count output, instantiated once. Pop control and the counter stay in the top.

Test Plan:
1. Basic drain: write 8 words 0x11,0x22,...,0x88 on the write side; out_ready=1, enable=1 → out_data sequence 0x11..0x88 on consecutive cycles after first out_valid; word_count=8; busy=0 afterwards.
2. Backpressure: 4 words 0xA0..0xA3, out_ready=0 for 10 cycles → rd_en pulses exactly twice; out_data holds 0xA0 stable. Then out_ready=1 → 0xA0,0xA1,0xA2,0xA3 in order with no gaps beyond the refill latency.
3. Alternating out_ready (1,0,1,0...) on 16 words 0x00..0x0F → all 16 delivered in order; count never exceeds 2; word_count=16.
4. enable low: assert enable=0 while 2 words are buffered and 5 remain in the FIFO → the 2 buffered words drain, rd_en stays 0. Then enable=1 → the remaining 5 drain; total word_count=7.
5. Reset mid-operation: with count=2 and a pop in flight, pulse rst for 1 cycle → next cycle out_valid=0, out_data=0, word_count=0, rd_en=0 during reset; no stale word appears afterwards.
6. Counter wrap with CNT_WIDTH=4: stream 18 words → word_count reads 2.
